// File: rtl/kaipokrandt_bus_pkg.sv
// Shared types and constants for the tristate register-bus sequencer.
package kaipokrandt_bus_pkg;

    localparam int unsigned BUS_WIDTH = 16;
    localparam int unsigned MAX_NREG  = 16;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/kaipokrandt_onehot_dec.sv
// Index-to-one-hot decoder with a global enable; all zero when disabled.
module kaipokrandt_onehot_dec
    import kaipokrandt_bus_pkg::*;
#(
    parameter int unsigned NREG  = 4,
    parameter int unsigned SEL_W = 4
) (
    input  logic [SEL_W-1:0] idx_i,
    input  logic             en_i,
    output logic [NREG-1:0]  onehot_c_o
);

    // Assert exactly the selected bit when enabled.
    always_comb begin
        onehot_c_o = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            onehot_c_o[i] = en_i && (idx_i == SEL_W'(i));
        end
    end

endmodule

// File: rtl/kaipokrandt_bus_sequencer.sv
// Register-to-register move sequencer for the shared tristate bus.
// Guarantees a single bus driver per cycle via IDLE/DRIVE/LOAD/DONE sequencing.
// Optional immediate source compiled in with KAIPOKRANDT_BUSSEQ_IMM_EN.
module kaipokrandt_bus_sequencer
    import kaipokrandt_bus_pkg::*;
#(
    parameter int unsigned NREG  = 4,
    parameter int unsigned WIDTH = BUS_WIDTH,
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_src,
    input  logic [SEL_W-1:0] req_dst,
    input  logic             req_imm,
    input  logic [WIDTH-1:0] req_data,
    output logic [NREG-1:0]  reg_enable,
    output logic [NREG-1:0]  reg_load,
    output logic [WIDTH-1:0] bus_out,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] xfer_count
);

    if ((NREG < 2) || (NREG > MAX_NREG) || ((2 ** SEL_W) < NREG)) begin : g_bad_cfg
        $error("kaipokrandt_bus_sequencer: illegal NREG/SEL_W combination");
    end

    state_e           state_q, state_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] dst_q, dst_d;
    logic             imm_q, imm_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREG-1:0]  en_q, ld_q;
    logic [NREG-1:0]  en_c, ld_c;
    logic             ready_q, done_q, err_q;
    logic             drive_en_c, load_en_c;
    logic             src_ok_c, dst_ok_c, req_legal_c;

    // Range checks on the incoming select fields.
    assign src_ok_c = ({1'b0, req_src} < (SEL_W + 1)'(NREG));
    assign dst_ok_c = ({1'b0, req_dst} < (SEL_W + 1)'(NREG));

`ifdef KAIPOKRANDT_BUSSEQ_IMM_EN
    logic [WIDTH-1:0] data_q, data_d;
    logic             drv_q, drv_d;

    assign req_legal_c = dst_ok_c && (req_imm || src_ok_c);
    assign bus_out     = drv_q ? data_q : 'z;
`else
    logic unused_data;

    assign unused_data = ^req_data;
    assign req_legal_c = dst_ok_c && src_ok_c && !req_imm;
    assign bus_out     = 'z;
`endif

    // Next-state, request capture and next-cycle output selection.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        imm_d   = imm_q;
        flag_d  = flag_q;
`ifdef KAIPOKRANDT_BUSSEQ_IMM_EN
        data_d  = data_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    src_d   = req_src;
                    dst_d   = req_dst;
                    imm_d   = req_imm;
`ifdef KAIPOKRANDT_BUSSEQ_IMM_EN
                    data_d  = req_data;
`endif
                    flag_d  = !req_legal_c;
                    state_d = req_legal_c ? DRIVE : DONE;
                end
            end
            DRIVE:   state_d = LOAD;
            LOAD:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        drive_en_c = ((state_d == DRIVE) || (state_d == LOAD)) && !imm_d;
        load_en_c  = (state_d == LOAD);
`ifdef KAIPOKRANDT_BUSSEQ_IMM_EN
        drv_d      = ((state_d == DRIVE) || (state_d == LOAD)) && imm_d;
`endif
        // Only a legal transfer passes through LOAD, so leaving it counts one.
        cnt_d = (state_q == LOAD) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    kaipokrandt_onehot_dec #(
        .NREG  (NREG),
        .SEL_W (SEL_W)
    ) u_enable_dec (
        .idx_i      (src_d),
        .en_i       (drive_en_c),
        .onehot_c_o (en_c)
    );

    kaipokrandt_onehot_dec #(
        .NREG  (NREG),
        .SEL_W (SEL_W)
    ) u_load_dec (
        .idx_i      (dst_d),
        .en_i       (load_en_c),
        .onehot_c_o (ld_c)
    );

    // State, holding and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            imm_q   <= 1'b0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
            en_q    <= '0;
            ld_q    <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef KAIPOKRANDT_BUSSEQ_IMM_EN
            data_q  <= '0;
            drv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            imm_q   <= imm_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            en_q    <= en_c;
            ld_q    <= ld_c;
            ready_q <= (state_d == IDLE);
            done_q  <= (state_d == DONE);
            err_q   <= (state_d == DONE) && flag_d;
`ifdef KAIPOKRANDT_BUSSEQ_IMM_EN
            data_q  <= data_d;
            drv_q   <= drv_d;
`endif
        end
    end

    assign req_ready  = ready_q;
    assign reg_enable = en_q;
    assign reg_load   = ld_q;
    assign done       = done_q;
    assign err        = err_q;
    assign xfer_count = cnt_q;

endmodule
